// File: rtl/raster_scan_ctrl.sv
// raster_scan_ctrl: walks one rasterizer across a 32x32 tile and streams per-row coverage masks.
// Optional `COVERAGE_COUNT_EN adds tile_cov/tile_cov_valid (set-bit count per tile).
module raster_scan_ctrl #(
   parameter int FIFO_DEPTH = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        job_valid,
   output logic        job_ready,
   input  logic        job_clear,
   input  logic [56:0] job_a,
   input  logic [71:0] job_b,
   input  logic [95:0] job_w,
   output logic [56:0] rast_a,
   output logic [71:0] rast_b,
   output logic [95:0] rast_w,
   output logic        rast_start,
   output logic        rast_enable,
   output logic        rast_clear,
   output logic [4:0]  rast_x,
   output logic [4:0]  rast_y,
   input  logic        rast_pixel,
   input  logic        rast_clear_pixel,
   output logic        row_valid,
   input  logic        row_ready,
   output logic [31:0] row_mask,
   output logic [4:0]  row_y,
   output logic        row_last,
`ifdef COVERAGE_COUNT_EN
   output logic [10:0] tile_cov,
   output logic        tile_cov_valid,
`endif
   output logic        busy
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] SPACE_LIMIT = CW'(FIFO_DEPTH - 32);
   localparam logic [PW-1:0] LAST_PTR    = PW'(FIFO_DEPTH - 1);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_LOAD, S_SCAN, S_DRAIN} state_t;

   state_t        state_reg;
   logic          job_ready_reg;
   logic          rast_start_reg;
   logic          rast_enable_reg;
   logic          rast_clear_reg;
   logic [4:0]    rast_x_reg;
   logic [4:0]    rast_y_reg;
   logic [56:0]   rast_a_reg;
   logic [71:0]   rast_b_reg;
   logic [95:0]   rast_w_reg;

   logic          enable_d_reg;
   logic [4:0]    x_d_reg;
   logic [4:0]    y_d_reg;
   logic [31:0]   mask_reg;
   logic [31:0]   mask_next;
   logic          cap_bit;
   logic          push;
   logic          pop;

   logic [37:0]   fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic [37:0]   head;
   logic          space_ok;

   // With one full tile of room the scan can never overflow the FIFO, so SCAN never stalls.
   assign space_ok = (count_reg <= SPACE_LIMIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= S_IDLE;
         job_ready_reg   <= 1'b0;
         rast_start_reg  <= 1'b0;
         rast_enable_reg <= 1'b0;
         rast_clear_reg  <= 1'b0;
         rast_x_reg      <= '0;
         rast_y_reg      <= '0;
         rast_a_reg      <= '0;
         rast_b_reg      <= '0;
         rast_w_reg      <= '0;
      end else begin
         rast_start_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               job_ready_reg <= 1'b1;
               if (job_valid && job_ready_reg) begin
                  rast_a_reg     <= job_a;
                  rast_b_reg     <= job_b;
                  rast_w_reg     <= job_w;
                  rast_clear_reg <= job_clear;
                  job_ready_reg  <= 1'b0;
                  if (space_ok) begin
                     state_reg      <= S_LOAD;
                     rast_start_reg <= 1'b1;
                  end else begin
                     state_reg <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (space_ok) begin
                  state_reg      <= S_LOAD;
                  rast_start_reg <= 1'b1;
               end
            end
            S_LOAD: begin
               state_reg       <= S_SCAN;
               rast_enable_reg <= 1'b1;
               rast_x_reg      <= '0;
               rast_y_reg      <= '0;
            end
            S_SCAN: begin
               if (rast_x_reg == 5'd31 && rast_y_reg == 5'd31) begin
                  state_reg       <= S_DRAIN;
                  rast_enable_reg <= 1'b0;
                  rast_x_reg      <= '0;
                  rast_y_reg      <= '0;
               end else begin
                  rast_x_reg <= rast_x_reg + 5'd1;
                  if (rast_x_reg == 5'd31)
                     rast_y_reg <= rast_y_reg + 5'd1;
               end
            end
            S_DRAIN: begin
               state_reg     <= S_IDLE;
               job_ready_reg <= 1'b1;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   // Rasterizer answers one cycle after the drive, so capture against delayed coordinates.
   assign cap_bit = rast_clear_reg ? rast_clear_pixel : rast_pixel;
   assign push    = enable_d_reg && (x_d_reg == 5'd31);

   generate
      for (genvar gi = 0; gi < 32; gi++) begin : g_mask
         assign mask_next[gi] = mask_reg[gi] | (enable_d_reg && cap_bit && (x_d_reg == 5'(gi)));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         enable_d_reg <= 1'b0;
         x_d_reg      <= '0;
         y_d_reg      <= '0;
         mask_reg     <= '0;
      end else begin
         enable_d_reg <= rast_enable_reg;
         x_d_reg      <= rast_x_reg;
         y_d_reg      <= rast_y_reg;
         if (enable_d_reg)
            mask_reg <= push ? '0 : mask_next;
      end
   end

   assign pop = row_valid && row_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push)
            wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PW'(1);
         if (pop)
            rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PW'(1);
         if (push && !pop)
            count_reg <= count_reg + CW'(1);
         else if (!push && pop)
            count_reg <= count_reg - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr_reg] <= {mask_next, y_d_reg, (y_d_reg == 5'd31)};
   end

   // Head is masked while empty so the stream outputs read 0 after reset.
   assign head      = fifo_mem[rd_ptr_reg];
   assign row_valid = (count_reg != '0);
   assign row_mask  = row_valid ? head[37:6] : '0;
   assign row_y     = row_valid ? head[5:1]  : '0;
   assign row_last  = row_valid ? head[0]    : 1'b0;

`ifdef COVERAGE_COUNT_EN
   logic [10:0] cov_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cov_reg <= '0;
      else if (state_reg == S_LOAD)
         cov_reg <= '0;
      else if (enable_d_reg && cap_bit)
         cov_reg <= cov_reg + 11'd1;
   end

   // The last pixel lands during DRAIN, so fold it in combinationally for the pulse.
   assign tile_cov       = cov_reg + {10'd0, (enable_d_reg && cap_bit)};
   assign tile_cov_valid = (state_reg == S_DRAIN);
`endif

   assign job_ready   = job_ready_reg;
   assign rast_start  = rast_start_reg;
   assign rast_enable = rast_enable_reg;
   assign rast_clear  = rast_clear_reg;
   assign rast_x      = rast_x_reg;
   assign rast_y      = rast_y_reg;
   assign rast_a      = rast_a_reg;
   assign rast_b      = rast_b_reg;
   assign rast_w      = rast_w_reg;
   assign busy        = (state_reg != S_IDLE) || row_valid;

endmodule

// File: tb/tb_raster_scan_ctrl.sv
// tb_raster_scan_ctrl: directed bench with a one-cycle rasterizer model and a row-stream monitor.
`timescale 1ns/1ps
module tb_raster_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        job_valid, job_ready, job_clear;
   logic [56:0] job_a, rast_a;
   logic [71:0] job_b, rast_b;
   logic [95:0] job_w, rast_w;
   logic        rast_start, rast_enable, rast_clear;
   logic [4:0]  rast_x, rast_y;
   logic        rast_pixel, rast_clear_pixel;
   logic        row_valid, row_ready, row_last, busy;
   logic [31:0] row_mask;
   logic [4:0]  row_y;
`ifdef COVERAGE_COUNT_EN
   logic [10:0] tile_cov;
   logic        tile_cov_valid;
`endif

   always #5 clk = ~clk;

   raster_scan_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .job_valid(job_valid), .job_ready(job_ready), .job_clear(job_clear),
      .job_a(job_a), .job_b(job_b), .job_w(job_w),
      .rast_a(rast_a), .rast_b(rast_b), .rast_w(rast_w),
      .rast_start(rast_start), .rast_enable(rast_enable), .rast_clear(rast_clear),
      .rast_x(rast_x), .rast_y(rast_y),
      .rast_pixel(rast_pixel), .rast_clear_pixel(rast_clear_pixel),
      .row_valid(row_valid), .row_ready(row_ready), .row_mask(row_mask),
      .row_y(row_y), .row_last(row_last),
`ifdef COVERAGE_COUNT_EN
      .tile_cov(tile_cov), .tile_cov_valid(tile_cov_valid),
`endif
      .busy(busy)
   );

   int acnt = 0;
   int fcnt = 0;

   // Rasterizer model: answers for the coordinate driven one cycle earlier.
   logic [1:0] pix_mode = 2'd0;
   logic       clr_mode = 1'b0;
   logic [4:0] mx_d = '0;
   logic [4:0] my_d = '0;
   always @(posedge clk) begin
      mx_d <= rast_x;
      my_d <= rast_y;
   end
   assign rast_pixel       = (pix_mode == 2'd1) || ((pix_mode == 2'd2) && (mx_d == my_d));
   assign rast_clear_pixel = clr_mode;

   // Monitor samples mid-low-phase, after the bench's input drives at negedge+1.
   logic [37:0] rec [256];
   int          rows_n = 0;
   int          start_cnt = 0;
   int          bad_start = 0;
   int          en_run = 0;
   int          last_run = 0;
   logic [10:0] last_cov = '0;
   always begin
      @(negedge clk);
      #2;
      if (row_valid && row_ready && rows_n < 256) begin
         rec[rows_n] = {row_mask, row_y, row_last};
         rows_n++;
      end
      if (rast_start) begin
         start_cnt++;
         if (rast_enable) bad_start++;
      end
      if (rast_enable) en_run++;
      else if (en_run != 0) begin
         last_run = en_run;
         en_run   = 0;
      end
`ifdef COVERAGE_COUNT_EN
      if (tile_cov_valid) last_cov = tile_cov;
`endif
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      acnt++;
      assert (obs === exp) else begin
         fcnt++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic send_job(input logic clr, input logic [56:0] a, input logic [71:0] b,
                           input logic [95:0] w);
      int n = 0;
      job_clear = clr;
      job_a     = a;
      job_b     = b;
      job_w     = w;
      job_valid = 1'b1;
      while (!job_ready && n < 3000) begin
         tick();
         n++;
      end
      chk("job_accept_timeout", (n < 3000), 1'b1);
      tick();
      job_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 3000) begin
         tick();
         n++;
      end
      chk("idle_timeout", (n < 3000), 1'b1);
   endtask

   task automatic check_rows(input int base, input logic full);
      logic [31:0] m;
      for (int i = 0; i < 32; i++) begin
         m = full ? 32'hFFFF_FFFF : (32'd1 << i);
         chk($sformatf("row%0d", i), rec[base + i], {m, 5'(i), (i == 31)});
      end
   endtask

   int base;
   int s0;
   int n;

   initial begin
      job_valid = 1'b0;
      job_clear = 1'b0;
      job_a     = '0;
      job_b     = '0;
      job_w     = '0;
      row_ready = 1'b1;

      // Reset state
      repeat (3) tick();
      chk("rst_job_ready", job_ready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_row_valid", row_valid, 1'b0);
      chk("rst_start", rast_start, 1'b0);
      chk("rst_enable", rast_enable, 1'b0);
      chk("rst_xy", {rast_x, rast_y}, 10'd0);
      chk("rst_clear", rast_clear, 1'b0);
      chk("rst_coef", {rast_a, rast_b, rast_w} == '0, 1'b1);
      chk("rst_row_mask", row_mask, 32'd0);
      rst_n = 1'b1;
      tick();
      chk("idle_job_ready", job_ready, 1'b1);

      // Full cover with start/enable timing
      pix_mode = 2'd1;
      clr_mode = 1'b0;
      send_job(1'b0, 57'h123_4567_89AB, 72'hDE_ADBE_EF01_2345_6789, 96'hCAFE_F00D_1234_5678_9ABC_DEF0);
      chk("load_start", rast_start, 1'b1);
      chk("load_enable", rast_enable, 1'b0);
      chk("load_a", rast_a, 57'h123_4567_89AB);
      chk("load_b", rast_b, 72'hDE_ADBE_EF01_2345_6789);
      chk("load_w", rast_w, 96'hCAFE_F00D_1234_5678_9ABC_DEF0);
      chk("load_clear", rast_clear, 1'b0);
      chk("load_job_ready", job_ready, 1'b0);
      chk("load_busy", busy, 1'b1);
      tick();
      chk("scan0_start", rast_start, 1'b0);
      chk("scan0_enable", rast_enable, 1'b1);
      chk("scan0_xy", {rast_x, rast_y}, 10'd0);
      tick();
      chk("scan1_x", rast_x, 5'd1);
      repeat (31) tick();
      chk("first_row_early", row_valid, 1'b0);
      tick();
      chk("first_row_valid", row_valid, 1'b1);
      chk("first_row_y", row_y, 5'd0);
      wait_idle();
      chk("full_start_cnt", start_cnt, 1);
      chk("full_enable_run", last_run, 1024);
      chk("full_rows", rows_n, 32);
      chk("start_with_enable", bad_start, 0);
      check_rows(0, 1'b1);
`ifdef COVERAGE_COUNT_EN
      chk("full_cov", last_cov, 11'd1024);
`endif

      // Diagonal
      base     = rows_n;
      pix_mode = 2'd2;
      send_job(1'b0, 57'h1, 72'h2, 96'h3);
      wait_idle();
      chk("diag_rows", rows_n - base, 32);
      chk("diag_start_cnt", start_cnt, 2);
      chk("diag_enable_run", last_run, 1024);
      check_rows(base, 1'b0);
`ifdef COVERAGE_COUNT_EN
      chk("diag_cov", last_cov, 11'd32);
`endif

      // Clear job: mask comes from rast_clear_pixel only
      base     = rows_n;
      pix_mode = 2'd0;
      clr_mode = 1'b1;
      send_job(1'b1, 57'h4, 72'h5, 96'h6);
      chk("clear_mode", rast_clear, 1'b1);
      wait_idle();
      chk("clear_rows", rows_n - base, 32);
      check_rows(base, 1'b1);
`ifdef COVERAGE_COUNT_EN
      chk("clear_cov", last_cov, 11'd1024);
`endif
      clr_mode = 1'b0;

      // Backpressure: full FIFO forces the second job into WAIT
      base      = rows_n;
      row_ready = 1'b0;
      pix_mode  = 2'd1;
      send_job(1'b0, 57'h7, 72'h8, 96'h9);
      repeat (1030) tick();
      chk("bp_fifo_full", row_valid, 1'b1);
      chk("bp_idle_ready", job_ready, 1'b1);
      s0       = start_cnt;
      pix_mode = 2'd2;
      send_job(1'b0, 57'h1AB, 72'h2CD, 96'h3EF);
      chk("wait_job_ready", job_ready, 1'b0);
      chk("wait_start", rast_start, 1'b0);
      chk("wait_coef_a", rast_a, 57'h1AB);
      chk("wait_busy", busy, 1'b1);
      repeat (20) tick();
      chk("wait_no_start", start_cnt, s0);
      chk("wait_no_pop", rows_n, base);
      row_ready = 1'b1;
      n = 0;
      while (!rast_start && n < 100) begin
         tick();
         n++;
      end
      chk("wait_load_timeout", (n < 100), 1'b1);
      chk("wait_popped_before_load", rows_n - base, 32);
      chk("wait_load_enable", rast_enable, 1'b0);
      wait_idle();
      chk("bp_rows", rows_n - base, 64);
      chk("bp_first_row", rec[base], {32'hFFFF_FFFF, 5'd0, 1'b0});
      check_rows(base + 32, 1'b0);

      // Reset mid-scan
      row_ready = 1'b0;
      pix_mode  = 2'd1;
      send_job(1'b0, 57'hA, 72'hB, 96'hC);
      n = 0;
      while (!(rast_x == 5'd5 && rast_y == 5'd10) && n < 2000) begin
         tick();
         n++;
      end
      chk("mid_scan_reach", (n < 2000), 1'b1);
      chk("mid_scan_rows_held", row_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 1'b0);
      chk("abort_row_valid", row_valid, 1'b0);
      chk("abort_enable", rast_enable, 1'b0);
      chk("abort_xy", {rast_x, rast_y}, 10'd0);
      chk("abort_coef_a", rast_a, 57'd0);
      chk("abort_job_ready", job_ready, 1'b0);
      tick();
      rst_n     = 1'b1;
      row_ready = 1'b1;
      tick();
      base = rows_n;
      s0   = start_cnt;
      send_job(1'b0, 57'hD, 72'hE, 96'hF);
      chk("restart_start", rast_start, 1'b1);
      chk("restart_xy", {rast_x, rast_y}, 10'd0);
      tick();
      chk("restart_enable", rast_enable, 1'b1);
      chk("restart_scan_xy", {rast_x, rast_y}, 10'd0);
      wait_idle();
      chk("restart_rows", rows_n - base, 32);
      chk("restart_start_cnt", start_cnt, s0 + 1);
      chk("restart_enable_run", last_run, 1024);
      check_rows(base, 1'b1);
      chk("start_with_enable_end", bad_start, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", acnt, fcnt);
      $finish;
   end

endmodule
